// File: rtl/test_example_clk.sv
// ---------------------------------------------------------------------------
// test_example_clk
// Clocked serial bit-pattern detector. input1 is shifted into a history
// register on every rising clk edge; output1 is raised for one cycle when the
// last PAT_LEN sampled bits equal PATTERN (MSB = oldest, LSB = newest).
//
// Parameters
//   PAT_LEN  pattern length in bits (1..32)
//   PATTERN  target sequence
//   OVERLAP  1: overlapping matches allowed; 0: history discarded after a match
//
// Ports
//   clk      in   single clock, rising-edge active
//   reset    in   synchronous, active-low reset (0 = reset)
//   input1   in   serial data bit, sampled on the rising edge
//   output1  out  registered match flag, one cycle per detected match
// ---------------------------------------------------------------------------
module test_example_clk #(
    parameter int unsigned          PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
    parameter bit                   OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic input1,
    output logic output1
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] next_hist;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  next_fill;
    logic               match;

    // A one-bit history has no older bits to keep, so the shift degenerates
    // to a plain load; split at elaboration so no negative slice is formed.
    generate
        if (PAT_LEN == 1) begin : g_hist_single
            always_comb begin
                next_hist = input1;
            end
        end else begin : g_hist_shift
            always_comb begin
                next_hist = {hist[PAT_LEN-2:0], input1};
            end
        end
    endgenerate

    // The fill counter tracks how many real samples are in hist, so cleared
    // zeros never look like data (matters when PATTERN is all zeros).
    always_comb begin
        next_fill = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
        match     = (next_fill == FILL_FULL) && (next_hist == PATTERN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist    <= '0;
            fill    <= '0;
            output1 <= 1'b0;
        end else begin
            hist    <= next_hist;
            output1 <= match;
            fill    <= (match && !OVERLAP) ? '0 : next_fill;
        end
    end

endmodule

// File: tb/tb_test_example_clk.sv
// ---------------------------------------------------------------------------
// tb_test_example_clk
// Directed-vector bench for test_example_clk. Five detector instances share
// one clock, reset and input stream:
//   ov  : PATTERN 1011, OVERLAP 1
//   nov : PATTERN 1011, OVERLAP 0
//   z1  : PATTERN 0000, OVERLAP 1
//   z0  : PATTERN 0000, OVERLAP 0
//   p1  : PAT_LEN 1, PATTERN 1, OVERLAP 1
// Each step drives reset/input1 on the falling edge, then after the rising
// edge compares every output against a hand-computed {ov,nov,z1,z0,p1}.
// ---------------------------------------------------------------------------
module tb_test_example_clk;

    logic clk;
    logic reset;
    logic input1;
    logic out_ov, out_nov, out_z1, out_z0, out_p1;

    int unsigned vectors;
    int unsigned miscompares;
    int unsigned step_no;

    test_example_clk #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) dut_ov (
        .clk(clk), .reset(reset), .input1(input1), .output1(out_ov));
    test_example_clk #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) dut_nov (
        .clk(clk), .reset(reset), .input1(input1), .output1(out_nov));
    test_example_clk #(.PAT_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1)) dut_z1 (
        .clk(clk), .reset(reset), .input1(input1), .output1(out_z1));
    test_example_clk #(.PAT_LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b0)) dut_z0 (
        .clk(clk), .reset(reset), .input1(input1), .output1(out_z0));
    test_example_clk #(.PAT_LEN(1), .PATTERN(1'b1), .OVERLAP(1'b1)) dut_p1 (
        .clk(clk), .reset(reset), .input1(input1), .output1(out_p1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s step %0d observed=%b expected=%b", tag, step_no, observed, expected);
        end
    endtask

    // exp = {ov, nov, z1, z0, p1}
    task automatic apply(input logic r, input logic d, input logic [4:0] exp);
        @(negedge clk);
        reset  = r;
        input1 = d;
        @(posedge clk);
        #1;
        step_no++;
        check("ov",  out_ov,  exp[4]);
        check("nov", out_nov, exp[3]);
        check("z1",  out_z1,  exp[2]);
        check("z0",  out_z0,  exp[1]);
        check("p1",  out_p1,  exp[0]);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        step_no     = 0;
        reset       = 1'b0;
        input1      = 1'bx;

        // Reset for two edges with an unknown input: everything low.
        apply(1'b0, 1'bx, 5'b00000);
        apply(1'b0, 1'bx, 5'b00000);

        // Twelve zeros: 1011 never matches; all-zero pattern needs four real
        // samples first, then stays high (overlap) or fires every 4th edge.
        apply(1'b1, 1'b0, 5'b00000);
        apply(1'b1, 1'b0, 5'b00000);
        apply(1'b1, 1'b0, 5'b00000);
        apply(1'b1, 1'b0, 5'b00110);  // edge 4
        apply(1'b1, 1'b0, 5'b00100);
        apply(1'b1, 1'b0, 5'b00100);
        apply(1'b1, 1'b0, 5'b00100);
        apply(1'b1, 1'b0, 5'b00110);  // edge 8
        apply(1'b1, 1'b0, 5'b00100);
        apply(1'b1, 1'b0, 5'b00100);
        apply(1'b1, 1'b0, 5'b00100);
        apply(1'b1, 1'b0, 5'b00110);  // edge 12

        // Stream 1,0,1,1,0,1,1 after reset: overlap matches at edges 4 and 7,
        // non-overlap only at edge 4 (fill cleared, only 3 samples by edge 7).
        apply(1'b0, 1'b0, 5'b00000);
        apply(1'b1, 1'b1, 5'b00001);
        apply(1'b1, 1'b0, 5'b00000);
        apply(1'b1, 1'b1, 5'b00001);
        apply(1'b1, 1'b1, 5'b11001);  // edge 4
        apply(1'b1, 1'b0, 5'b00000);
        apply(1'b1, 1'b1, 5'b00001);
        apply(1'b1, 1'b1, 5'b10001);  // edge 7

        // 1,0,1 then reset then 1: would have completed 1011 without the
        // reset, so must stay low. Then 0,1,1 completes 1,0,1,1 sampled
        // entirely after reset, which does match on its fourth edge.
        apply(1'b0, 1'b0, 5'b00000);
        apply(1'b1, 1'b1, 5'b00001);
        apply(1'b1, 1'b0, 5'b00000);
        apply(1'b1, 1'b1, 5'b00001);
        apply(1'b0, 1'b1, 5'b00000);  // reset edge ignores input1
        apply(1'b1, 1'b1, 5'b00001);
        apply(1'b1, 1'b0, 5'b00000);
        apply(1'b1, 1'b1, 5'b00001);
        apply(1'b1, 1'b1, 5'b11001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
